// File: rtl/glyph_pixel_pipe.sv
// glyph_pixel_pipe: 3-stage text-mode pixel pipeline, unified 8x16 font with integer scaling, blink and inverse video.
// Ports: clk, reset (sync, active-high); pix_en advances the pipeline; frame_tick drives the blink counter;
// video_on_in/hsync_in/vsync_in, pixel_x/pixel_y, char_code, attr_blink/attr_inv, fg_rgb/bg_rgb are sampled on pix_en;
// rgb_out, hsync_out, vsync_out, video_on_out, glyph_bit appear 3 pix_en steps later; blink_phase is the live blink state.
module glyph_pixel_pipe #(
  parameter int CODE_W       = 5,
  parameter int SCALE_LOG2   = 0,
  parameter int X_W          = 10,
  parameter int RGB_W        = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              frame_tick,
  input  logic              video_on_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [X_W-1:0]    pixel_x,
  input  logic [X_W-1:0]    pixel_y,
  input  logic [CODE_W-1:0] char_code,
  input  logic              attr_blink,
  input  logic              attr_inv,
  input  logic [RGB_W-1:0]  fg_rgb,
  input  logic [RGB_W-1:0]  bg_rgb,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_on_out,
  output logic              glyph_bit,
  output logic              blink_phase
);
  // Each glyph is 16 rows packed with row 0 in the top byte; bit 7 of a row is the leftmost pixel.
  function automatic logic [127:0] glyph(input int c);
    case (c)
      0:  glyph = 128'h003C4242_42424242_42424242_423C0000;
      1:  glyph = 128'h00081828_08080808_08080808_083E0000;
      2:  glyph = 128'h003C4202_02040810_20404040_407E0000;
      3:  glyph = 128'h003C4202_02021C02_02020202_423C0000;
      4:  glyph = 128'h00040C14_2444447E_04040404_04040000;
      5:  glyph = 128'h007E4040_407C0202_02020202_423C0000;
      6:  glyph = 128'h003C4040_407C4242_42424242_423C0000;
      7:  glyph = 128'h007E0202_04040808_10101010_10100000;
      8:  glyph = 128'h003C4242_42423C42_42424242_423C0000;
      9:  glyph = 128'h003C4242_4242423E_02020202_023C0000;
      10: glyph = 128'h00000000_00300000_00000030_00000000;
      11: glyph = 128'h04040404_08080808_10101010_20202040;
      12: glyph = 128'h00001038_44444444_4444FE00_10000000;
      13: glyph = 128'h00000000_387CFEFE_FE7C3800_00000000;
      15: glyph = 128'h00182442_42427E42_42424242_42420000;
      16: glyph = 128'h003C4240_40404040_40404040_423C0000;
      17: glyph = 128'h007E4040_40407C40_40404040_407E0000;
      18: glyph = 128'h007E4040_40407C40_40404040_40400000;
      19: glyph = 128'h00424242_42427E42_42424242_42420000;
      20: glyph = 128'h003E0808_08080808_08080808_083E0000;
      21: glyph = 128'h0042665A_5A424242_42424242_42420000;
      22: glyph = 128'h00182442_42424242_42424242_24180000;
      23: glyph = 128'h007C4242_42427C48_44444242_42420000;
      24: glyph = 128'h007F0808_08080808_08080808_08080000;
      default: glyph = '0;
    endcase
  endfunction
  logic [CODE_W-1:0] s1_code;
  logic [3:0]        s1_row;
  logic [2:0]        s1_col, s2_col;
  logic [7:0]        s2_byte, cnt;
  logic              s1_blink, s1_inv, s2_blink, s2_inv;
  logic [RGB_W-1:0]  s1_fg, s1_bg, s2_fg, s2_bg;
  logic [2:0]        s1_sync, s2_sync;
  logic [127:0]      g;
  logic              gb, lit;
  assign g   = glyph(int'(s1_code));
  assign gb  = s2_byte[~s2_col];
  // blink_phase here is the pre-tick value, so a same-cycle frame_tick only affects later pixels
  assign lit = (gb & ~(s2_blink & blink_phase)) ^ s2_inv;
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1_code, s1_row, s1_col, s1_blink, s1_inv, s1_fg, s1_bg, s1_sync} <= '0;
      {s2_byte, s2_col, s2_blink, s2_inv, s2_fg, s2_bg, s2_sync} <= '0;
      {rgb_out, glyph_bit, video_on_out, hsync_out, vsync_out} <= '0;
    end else if (pix_en) begin
      s1_code  <= char_code;
      s1_row   <= 4'(pixel_y >> SCALE_LOG2);
      s1_col   <= 3'(pixel_x >> SCALE_LOG2);
      s1_blink <= attr_blink;
      s1_inv   <= attr_inv;
      s1_fg    <= fg_rgb;
      s1_bg    <= bg_rgb;
      s1_sync  <= {video_on_in, hsync_in, vsync_in};
      s2_byte  <= g[{~s1_row, 3'b000} +: 8];
      s2_col   <= s1_col;
      s2_blink <= s1_blink;
      s2_inv   <= s1_inv;
      s2_fg    <= s1_fg;
      s2_bg    <= s1_bg;
      s2_sync  <= s1_sync;
      glyph_bit <= gb;
      rgb_out   <= s2_sync[2] ? (lit ? s2_fg : s2_bg) : '0;
      {video_on_out, hsync_out, vsync_out} <= s2_sync;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      cnt         <= (cnt == 8'(BLINK_FRAMES - 1)) ? '0 : cnt + 8'd1;
      blink_phase <= blink_phase ^ (cnt == 8'(BLINK_FRAMES - 1));
    end
  end
endmodule

// File: tb/tb_glyph_pixel_pipe.sv
// tb_glyph_pixel_pipe: two instances (unscaled with 2-frame blink, 2x scaled with 3-frame blink) against a behavioural model.
module tb_glyph_pixel_pipe;
  logic clk = 0;
  logic reset, pix_en, frame_tick, video_on_in, hsync_in, vsync_in, attr_blink, attr_inv;
  logic [9:0] pixel_x, pixel_y;
  logic [4:0] char_code;
  logic [7:0] fg_rgb, bg_rgb;
  logic [7:0] rgb0, rgb1;
  logic hs0, hs1, vs0, vs1, vo0, vo1, gb0, gb1, ph0, ph1;
  always #5 clk = ~clk;
  glyph_pixel_pipe #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) d0 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .frame_tick(frame_tick),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .char_code(char_code),
    .attr_blink(attr_blink), .attr_inv(attr_inv), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .rgb_out(rgb0), .hsync_out(hs0), .vsync_out(vs0), .video_on_out(vo0),
    .glyph_bit(gb0), .blink_phase(ph0));
  glyph_pixel_pipe #(.SCALE_LOG2(1), .BLINK_FRAMES(3)) d1 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .frame_tick(frame_tick),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .char_code(char_code),
    .attr_blink(attr_blink), .attr_inv(attr_inv), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .rgb_out(rgb1), .hsync_out(hs1), .vsync_out(vs1), .video_on_out(vo1),
    .glyph_bit(gb1), .blink_phase(ph1));
  typedef struct packed {
    logic [9:0] x, y;
    logic [4:0] code;
    logic bl, inv, vo, hs, vs;
    logic [7:0] fg, bg;
  } rec_t;
  rec_t cur, s1, s2;
  int cnt[2];
  bit ph[2], e_known[2];
  logic [7:0] e_rgb[2];
  logic e_gb[2], e_hs, e_vs, e_vo;
  int checks = 0, errors = 0;
  // Row byte for glyphs whose pixels are fixed by the font definition; -1 where the artwork is free.
  function automatic int font_byte(input int code, input int row);
    int ball[7] = '{'h38, 'h7C, 'hFE, 'hFE, 'hFE, 'h7C, 'h38};
    if (code == 0) return (row == 1 || row == 13) ? 'h3C : (row >= 2 && row <= 12) ? 'h42 : 0;
    if (code == 10) return (row == 5 || row == 11) ? 'h30 : 0;
    if (code == 11) return row == 0 ? 'h04 : row == 15 ? 'h40 : -1;
    if (code == 13) return (row >= 4 && row <= 10) ? ball[row-4] : 0;
    if (code == 14 || code >= 25) return 0;
    if (code == 12) return -1;
    return (row == 0 || row >= 14) ? 0 : -1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  // d selects the instance: scale is 2**d and the blink half-period is d+2 frames.
  task automatic step(input bit r, input bit en, input bit tk);
    reset = r; pix_en = en; frame_tick = tk;
    pixel_x = cur.x; pixel_y = cur.y; char_code = cur.code;
    attr_blink = cur.bl; attr_inv = cur.inv; video_on_in = cur.vo;
    hsync_in = cur.hs; vsync_in = cur.vs; fg_rgb = cur.fg; bg_rgb = cur.bg;
    @(posedge clk);
    if (r) begin
      s1 = '0; s2 = '0; e_hs = 0; e_vs = 0; e_vo = 0;
      for (int d = 0; d < 2; d++) begin
        cnt[d] = 0; ph[d] = 0; e_rgb[d] = 0; e_gb[d] = 0; e_known[d] = 1;
      end
    end else begin
      if (en) begin
        for (int d = 0; d < 2; d++) begin
          int row, col, fb;
          bit g, lit;
          row = (int'(s2.y) >> d) % 16;
          col = (int'(s2.x) >> d) % 8;
          fb = font_byte(int'(s2.code), row);
          e_known[d] = fb >= 0;
          if (fb >= 0) begin
            g = ((fb >> (7 - col)) & 1) != 0;
            lit = (g && !(s2.bl && ph[d])) != s2.inv;
            e_gb[d] = g;
            e_rgb[d] = s2.vo ? (lit ? s2.fg : s2.bg) : 8'h00;
          end
        end
        e_hs = s2.hs; e_vs = s2.vs; e_vo = s2.vo;
        s2 = s1; s1 = cur;
      end
      if (tk)
        for (int d = 0; d < 2; d++)
          if (cnt[d] == d + 1) begin cnt[d] = 0; ph[d] = !ph[d]; end
          else cnt[d]++;
    end
    #1;
    chk("hsync0", hs0, e_hs); chk("vsync0", vs0, e_vs); chk("video0", vo0, e_vo);
    chk("hsync1", hs1, e_hs); chk("vsync1", vs1, e_vs); chk("video1", vo1, e_vo);
    chk("phase0", ph0, ph[0]); chk("phase1", ph1, ph[1]);
    if (e_known[0]) begin chk("glyph0", gb0, e_gb[0]); chk("rgb0", rgb0, e_rgb[0]); end
    if (e_known[1]) begin chk("glyph1", gb1, e_gb[1]); chk("rgb1", rgb1, e_rgb[1]); end
  endtask
  initial begin
    logic [7:0] exp_digit[8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    logic [3:0] exp_b0 = 4'b0110, exp_b1 = 4'b1100;
    int picks[10] = '{0, 0, 10, 11, 13, 13, 14, 25, 31, 0};
    cur = '0;
    step(1, 1, 1);
    step(1, 0, 0);
    chk("reset rgb0", rgb0, 0); chk("reset blink0", ph0, 0);
    cur.code = 0; cur.y = 1; cur.vo = 1; cur.fg = 8'hFF; cur.bg = 8'h00;
    for (int i = 0; i < 10; i++) begin
      cur.x = 10'(i % 8); cur.hs = i[0]; cur.vs = i[1];
      step(0, 1, 0);
      if (i >= 2) chk("digit0 row1", rgb0, exp_digit[i-2]);
    end
    cur.code = 13; cur.y = 12;
    for (int i = 0; i < 18; i++) begin
      cur.x = 10'(i % 16);
      step(0, 1, 0);
      if (i >= 2) chk("ball scaled", rgb1, (i - 2) < 14 ? 8'hFF : 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      cur.x = 10'($urandom_range(0, 1023)); cur.code = 5'(picks[i % 10]);
      step(0, i[0] == 0, 0);
    end
    step(1, 0, 0);
    cur.bl = 1; cur.code = 13; cur.y = 8; cur.x = 3;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1);
      chk("blink tick0", ph0, exp_b0[k]);
      chk("blink tick1", ph1, exp_b1[k]);
    end
    step(0, 1, 1);
    step(0, 1, 1);
    cur.inv = 1;
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(1, 1, 1);
    chk("midreset rgb0", rgb0, 0); chk("midreset blink0", ph0, 0); chk("midreset video0", vo0, 0);
    step(0, 0, 1);
    chk("post reset tick1", ph0, 0);
    step(0, 0, 1);
    chk("post reset tick2", ph0, 1);
    for (int i = 0; i < 800; i++) begin
      cur.x = 10'($urandom_range(0, 1023));
      cur.y = 10'($urandom_range(0, 1023));
      cur.code = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(picks[$urandom_range(0, 9)]);
      cur.bl = 1'($urandom_range(0, 1)); cur.inv = 1'($urandom_range(0, 1));
      cur.vo = $urandom_range(0, 4) != 0; cur.hs = 1'($urandom_range(0, 1)); cur.vs = 1'($urandom_range(0, 1));
      cur.fg = 8'($urandom_range(0, 255)); cur.bg = 8'($urandom_range(0, 255));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
